// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-GPR in-flight writer counters that gate uop issue from
// Decode into Data-Fetch. Issue is refused on any register overlap with a busy
// register, on counter saturation, on a memory stall, during flush or reset.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dc_valid,
  input  logic [NREGS-1:0] src_mask,
  input  logic [NREGS-1:0] dst_mask,
  input  logic             mem_blocked,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [NREGS-1:0] wb_mask,
  output logic             issue_ready,
  output logic             conflict,
  output logic [NREGS-1:0] busy,
  output logic             any_busy,
  output logic             err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_reg  [NREGS];
  logic [CNT_W-1:0] count_next [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] sat_vec;
  logic [NREGS-1:0] under_vec;
  logic             any_busy_reg;
  logic             err_underflow_reg;
  logic             conflict_raw;
  logic             sat_any;
  logic             issue_fire;
  logic             release_fire;

  // Hazard detection and issue gating; everything is held off while reset is high.
  always_comb begin
    conflict_raw = |((src_mask | dst_mask) & busy_reg);
    sat_any      = |sat_vec;
    issue_ready  = dc_valid && !conflict_raw && !sat_any && !mem_blocked
                   && !flush && !reset;
    conflict     = conflict_raw && !reset;
    issue_fire   = issue_ready;
    release_fire = wb_valid && !flush;
  end

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      logic inc;
      logic dec;

      assign sat_vec[gi] = dst_mask[gi] && (count_reg[gi] == CNT_MAX);
      assign inc         = issue_fire && dst_mask[gi];
      assign dec         = release_fire && wb_mask[gi];

      // Per-register count update: flush clears, simultaneous inc/dec cancels,
      // a release on an idle register holds zero and flags underflow.
      always_comb begin
        count_next[gi] = count_reg[gi];
        under_vec[gi]  = 1'b0;
        if (flush) begin
          count_next[gi] = CNT_ZERO;
        end else if (inc && !dec) begin
          count_next[gi] = count_reg[gi] + CNT_ONE;
        end else if (dec && !inc) begin
          if (count_reg[gi] == CNT_ZERO) begin
            under_vec[gi] = 1'b1;
          end else begin
            count_next[gi] = count_reg[gi] - CNT_ONE;
          end
        end
        busy_next[gi] = (count_next[gi] != CNT_ZERO);
      end

      // Count register for this GPR.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg[gi] <= CNT_ZERO;
        end else begin
          count_reg[gi] <= count_next[gi];
        end
      end
    end
  endgenerate

  // Busy vector and its OR track the counts so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg     <= '0;
      any_busy_reg <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      any_busy_reg <= |busy_next;
    end
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_underflow_reg <= 1'b0;
    end else if (|under_vec) begin
      err_underflow_reg <= 1'b1;
    end
  end

  assign busy          = busy_reg;
  assign any_busy      = any_busy_reg;
  assign err_underflow = err_underflow_reg;

endmodule
